// File: rtl/d_wbuf.sv
// d_wbuf: write-back buffer that absorbs dirty-line evictions and drains them to memory.
// Optional WBUF_FWD_EN: reads hitting a buffered line are answered from the buffer.
module d_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_wdata,
  output logic [DATA_W-1:0] cache_rdata,
  output logic              cache_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              cache_ready_q, cache_ready_d;
  logic [DATA_W-1:0] cache_rdata_q, cache_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_empty_q, wb_empty_d;

  logic              rd_req, wr_req, head_locked;
  logic              rd_hit, wr_hit, push, coalesce, pop;
  logic [PTR_W-1:0]  wr_idx, scan_idx;
`ifdef WBUF_FWD_EN
  logic [PTR_W-1:0]  rd_idx;
`endif

  // The cycle showing cache_ready is dead: the still-held request must not be taken again.
  assign rd_req = cache_read && !cache_ready_q;
  assign wr_req = cache_write && !cache_read && !cache_ready_q;

  // Head is off-limits for coalescing while it is (or is about to be) on the memory bus.
  assign head_locked = (state_q == S_DRAIN) ||
                       ((state_q == S_IDLE) && !rd_req && (count_q != '0));

  // Scan oldest to youngest so the last match is the youngest entry.
  always_comb begin
    rd_hit   = 1'b0;
    wr_hit   = 1'b0;
    wr_idx   = head_q;
    scan_idx = head_q;
`ifdef WBUF_FWD_EN
    rd_idx   = head_q;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PTR_W'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == cache_addr)) begin
        rd_hit = 1'b1;
`ifdef WBUF_FWD_EN
        rd_idx = scan_idx;
`endif
        if (!(head_locked && (k == 0))) begin
          wr_hit = 1'b1;
          wr_idx = scan_idx;
        end
      end
    end
  end

  assign coalesce = wr_req && wr_hit;
  assign push     = wr_req && !wr_hit && (count_q != FULL);

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cache_rdata_d = cache_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
`ifdef WBUF_FWD_EN
          if (rd_hit) begin
            state_d       = S_RESP;
            cache_rdata_d = data_q[rd_idx];
          end
`else
          // Without forwarding, matching lines must reach memory before the read goes out.
          if (rd_hit) begin
            state_d     = S_DRAIN;
            mem_write_d = 1'b1;
            mem_addr_d  = addr_q[head_q];
            mem_wdata_d = data_q[head_q];
          end
`endif
          else begin
            state_d    = S_READ;
            mem_read_d = 1'b1;
            mem_addr_d = cache_addr;
          end
        end else if (count_q != '0) begin
          state_d     = S_DRAIN;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = data_q[head_q];
        end
      end
      S_DRAIN: begin
        if (mem_ready) begin
          pop         = 1'b1;
          mem_write_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_READ: begin
        if (mem_ready) begin
          mem_read_d    = 1'b0;
          cache_rdata_d = mem_rdata;
          state_d       = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d = valid_q;
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
    cache_ready_d = push || coalesce || (state_q == S_RESP);
    wb_empty_d    = (count_d == '0) && (state_d != S_DRAIN);
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      cache_ready_q <= 1'b0;
      cache_rdata_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_empty_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      cache_ready_q <= cache_ready_d;
      cache_rdata_q <= cache_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_empty_q    <= wb_empty_d;
    end
  end

  // Entry storage carries no reset; valid_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cache_addr;
      data_q[tail_q] <= cache_wdata;
    end else if (coalesce) begin
      data_q[wr_idx] <= cache_wdata;
    end
  end

  assign cache_ready = cache_ready_q;
  assign cache_rdata = cache_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_empty    = wb_empty_q;

endmodule

// File: tb/tb_d_wbuf.sv
// Directed bench for d_wbuf: cycle table with a hand-driven memory, then sequences with a fixed-latency memory.
module tb_d_wbuf;
  localparam int LAT = 8;

  logic         clk, proc_reset, cache_read, cache_write;
  logic [27:0]  cache_addr;
  logic [127:0] cache_wdata, cache_rdata;
  logic         cache_ready, mem_read, mem_write, mem_ready, wb_empty;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  logic         auto_mem, man_mrdy, rsp_ready;
  logic [127:0] man_mrdata, rsp_rdata;
  assign mem_ready = auto_mem ? rsp_ready : man_mrdy;
  assign mem_rdata = auto_mem ? rsp_rdata : man_mrdata;

  int checks, errors;

  d_wbuf #(.DEPTH(4), .ADDR_W(28), .DATA_W(128)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_ready(cache_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .wb_empty(wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Memory model: acks a request LAT samples after it appears and logs every transfer.
  logic [127:0] mem_arr [256];
  logic         ev_wr   [64];
  logic [27:0]  ev_addr [64];
  logic [127:0] ev_data [64];
  int           ev_n, rsp_cnt;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = {4{32'hC0DE_0000 + 32'(i)}};
    rsp_ready = 1'b0; rsp_rdata = '0; rsp_cnt = 0; ev_n = 0;
    forever begin
      @(posedge clk); #1;
      if (rsp_ready) begin
        rsp_ready = 1'b0; rsp_cnt = 0;
      end else if (auto_mem && (mem_read || mem_write)) begin
        rsp_cnt++;
        if (rsp_cnt >= LAT) begin
          rsp_ready = 1'b1; rsp_cnt = 0;
          if (mem_write) mem_arr[mem_addr[7:0]] = mem_wdata;
          else rsp_rdata = mem_arr[mem_addr[7:0]];
          if (ev_n < 64) begin
            ev_wr[ev_n] = mem_write; ev_addr[ev_n] = mem_addr;
            ev_data[ev_n] = mem_write ? mem_wdata : mem_arr[mem_addr[7:0]];
            ev_n++;
          end
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  typedef struct packed {
    logic rst, rd, wr; logic [27:0] addr; logic [127:0] wdata;
    logic mrdy; logic [127:0] mrdata;
    logic e_rdy; logic [127:0] e_rdata; logic e_mrd, e_mwr;
    logic [27:0] e_maddr; logic [127:0] e_mwdata; logic e_empty;
  } vec_t;

  function automatic vec_t mkv(input logic rst, rd, wr, input logic [27:0] addr,
                               input logic [127:0] wdata, input logic mrdy,
                               input logic [127:0] mrdata, input logic e_rdy,
                               input logic [127:0] e_rdata, input logic e_mrd, e_mwr,
                               input logic [27:0] e_maddr, input logic [127:0] e_mwdata,
                               input logic e_empty);
    return '{rst, rd, wr, addr, wdata, mrdy, mrdata, e_rdy, e_rdata, e_mrd, e_mwr,
             e_maddr, e_mwdata, e_empty};
  endfunction

  task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] outs();
    return 320'({cache_ready, cache_rdata, mem_read, mem_write, mem_addr, mem_wdata, wb_empty});
  endfunction

  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input int exp_cyc,
                          input string nm);
    int cyc;
    cache_addr = a; cache_wdata = d; cache_write = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!cache_ready && cyc < 300);
    cache_write = 1'b0;
    check(nm, 320'(cyc), 320'(exp_cyc));
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [27:0] a, input logic [127:0] exp_d, input string nm);
    int cyc;
    cache_addr = a; cache_read = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!cache_ready && cyc < 300);
    check(nm, 320'({cache_ready, cache_rdata}), 320'({1'b1, exp_d}));
    cache_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string nm);
    int cyc;
    cyc = 0;
    while (!wb_empty && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check(nm, 320'(wb_empty), 320'(1));
  endtask

  task automatic chk_ev(input string nm, input int idx, input logic wr,
                        input logic [27:0] a, input logic [127:0] d);
    if (idx < 64) check(nm, 320'({ev_wr[idx], ev_addr[idx], ev_data[idx]}), 320'({wr, a, d}));
    else check(nm, 320'(idx), 320'(0));
  endtask

  localparam logic [127:0] D1  = {4{32'hD1D1_0010}};
  localparam logic [127:0] R40 = {4{32'h5A5A_0040}};
  localparam logic [127:0] D30 = {4{32'hDEAD_BEEF}};

  vec_t vecs [11];
  int   base;

  initial begin
    checks = 0; errors = 0;
    auto_mem = 1'b0; man_mrdy = 1'b0; man_mrdata = '0;
    proc_reset = 1'b1; cache_read = 1'b0; cache_write = 1'b0;
    cache_addr = '0; cache_wdata = '0;

    vecs[0]  = mkv(1,0,0,28'h00,'0,0,'0,  0,'0,  0,0,28'h00,'0,1);
    vecs[1]  = mkv(0,0,1,28'h10,D1,0,'0,  1,'0,  0,0,28'h00,'0,0);
    vecs[2]  = mkv(0,0,1,28'h10,D1,0,'0,  0,'0,  0,1,28'h10,D1,0);
    vecs[3]  = mkv(0,0,0,28'h00,'0,0,'0,  0,'0,  0,1,28'h10,D1,0);
    vecs[4]  = mkv(0,0,0,28'h00,'0,1,'0,  0,'0,  0,0,28'h10,D1,1);
    vecs[5]  = mkv(0,1,0,28'h40,'0,0,'0,  0,'0,  1,0,28'h40,D1,1);
    vecs[6]  = mkv(0,1,0,28'h40,'0,0,'0,  0,'0,  1,0,28'h40,D1,1);
    vecs[7]  = mkv(0,1,0,28'h40,'0,1,R40, 0,R40, 0,0,28'h40,D1,1);
    vecs[8]  = mkv(0,1,0,28'h40,'0,0,'0,  1,R40, 0,0,28'h40,D1,1);
    vecs[9]  = mkv(0,1,0,28'h40,'0,0,'0,  0,R40, 0,0,28'h40,D1,1);
    vecs[10] = mkv(0,0,0,28'h00,'0,0,'0,  0,R40, 0,0,28'h40,D1,1);

    for (int i = 0; i < 11; i++) begin
      proc_reset = vecs[i].rst; cache_read = vecs[i].rd; cache_write = vecs[i].wr;
      cache_addr = vecs[i].addr; cache_wdata = vecs[i].wdata;
      man_mrdy = vecs[i].mrdy; man_mrdata = vecs[i].mrdata;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs(),
            320'({vecs[i].e_rdy, vecs[i].e_rdata, vecs[i].e_mrd, vecs[i].e_mwr,
                  vecs[i].e_maddr, vecs[i].e_mwdata, vecs[i].e_empty}));
    end
    cache_read = 1'b0; cache_write = 1'b0; man_mrdy = 1'b0;
    auto_mem = 1'b1;
    @(posedge clk); #1;

    // Eviction burst: four fill the buffer, the fifth waits for the first drain to retire.
    base = ev_n;
    for (int i = 0; i < 4; i++)
      do_write(28'h10 + 28'(i), {4{32'hB000_0010 + 32'(i)}}, 1, $sformatf("burst_lat%0d", i));
    do_write(28'h14, {4{32'hB000_0014}}, 3, "burst_stall");
    wait_empty("burst_empty");
    check("burst_nev", 320'(ev_n - base), 320'(5));
    for (int i = 0; i < 5; i++)
      chk_ev($sformatf("burst_ev%0d", i), base + i, 1'b1, 28'h10 + 28'(i),
             {4{32'hB000_0010 + 32'(i)}});

    // Coalesce: 0x20 sits behind the draining 0x1F, so the second write replaces its data.
    base = ev_n;
    do_write(28'h1F, {4{32'h1F1F_1F1F}}, 1, "coal_w1f");
    do_write(28'h20, {4{32'hAAAA_0020}}, 1, "coal_wa");
    do_write(28'h20, {4{32'hBBBB_0020}}, 1, "coal_wb");
    wait_empty("coal_empty");
    check("coal_nev", 320'(ev_n - base), 320'(2));
    chk_ev("coal_ev0", base, 1'b1, 28'h1F, {4{32'h1F1F_1F1F}});
    chk_ev("coal_ev1", base + 1, 1'b1, 28'h20, {4{32'hBBBB_0020}});

    // Read miss arriving while a drain is in flight.
    base = ev_n;
    do_write(28'h3F, {4{32'h3F3F_3F3F}}, 1, "miss_w3f");
    do_read(28'h40, {4{32'hC0DE_0040}}, "miss_rdata");
    wait_empty("miss_empty");
    check("miss_nev", 320'(ev_n - base), 320'(2));
    chk_ev("miss_ev0", base, 1'b1, 28'h3F, {4{32'h3F3F_3F3F}});
    chk_ev("miss_ev1", base + 1, 1'b0, 28'h40, {4{32'hC0DE_0040}});

    // Read of a line still held in the buffer.
    base = ev_n;
    do_write(28'h2F, {4{32'h2F2F_2F2F}}, 1, "hit_w2f");
    do_write(28'h30, D30, 1, "hit_w30");
    do_read(28'h30, D30, "hit_rdata");
    wait_empty("hit_empty");
    chk_ev("hit_ev0", base, 1'b1, 28'h2F, {4{32'h2F2F_2F2F}});
`ifdef WBUF_FWD_EN
    check("hit_nev", 320'(ev_n - base), 320'(2));
    chk_ev("hit_ev1", base + 1, 1'b1, 28'h30, D30);
`else
    check("hit_nev", 320'(ev_n - base), 320'(3));
    chk_ev("hit_ev1", base + 1, 1'b1, 28'h30, D30);
    chk_ev("hit_ev2", base + 2, 1'b0, 28'h30, D30);
`endif

    // Reset pulsed mid-drain with a write request held.
    base = ev_n;
    do_write(28'h50, {4{32'h5050_5050}}, 1, "rst_w50");
    #3;
    cache_addr = 28'h51; cache_wdata = {4{32'h5151_5151}}; cache_write = 1'b1;
    proc_reset = 1'b1;
    #1;
    check("rst_async", outs(), 320'({1'b0, 128'h0, 1'b0, 1'b0, 28'h0, 128'h0, 1'b1}));
    @(posedge clk); #1;
    check("rst_hold", outs(), 320'({1'b0, 128'h0, 1'b0, 1'b0, 28'h0, 128'h0, 1'b1}));
    proc_reset = 1'b0; cache_write = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_discard", 320'({wb_empty, mem_write}), 320'({1'b1, 1'b0}));
    check("rst_no_mem", 320'(ev_n - base), 320'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/d_wbuf.md
Name: d_wbuf

Overview:
- Write-back buffer between the data cache memory port and the off-chip memory model.
- Absorbs dirty-line evictions in a small FIFO, so the cache's WRITE_BACK state finishes in 2 cycles instead of a full memory latency.
- Drains buffered lines to memory in the background.
- Passes line-fill reads through to memory, serving them from the buffer when the line is still held there.

Parameters:
- DEPTH, 4, number of 128-bit line entries (power of 2, >=2)
- ADDR_W, 28, line address width
- DATA_W, 128, line width

Ports:
- clk  in  1  clock, rising edge
- proc_reset  in  1  asynchronous, active-high reset
- cache_read  in  1  line read request from cache, held until cache_ready
- cache_write  in  1  line write (eviction) request from cache, held until cache_ready
- cache_addr  in  ADDR_W  line address
- cache_wdata  in  DATA_W  eviction data
- cache_rdata  out  DATA_W  read data, valid while cache_ready=1 for a read
- cache_ready  out  1  one-cycle completion pulse
- mem_read  out  1  memory read, held until mem_ready
- mem_write  out  1  memory write, held until mem_ready
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
- wb_empty  out  1  buffer holds no entries

Behaviour:
- Reset (async): all entries invalid; FIFO pointers and count 0; state IDLE.
- Reset outputs: cache_ready=0, cache_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wb_empty=1.
- Reset mid-transaction aborts it; buffered data is discarded.
- All outputs are registered.
- The cycle in which cache_ready=1 is a dead cycle for the request sampler. The still-asserted request is not re-accepted.
- cache_read and cache_write are never both asserted. If they are, the read wins.
- Write accept, count<DEPTH:
  - cache_write sampled at edge N.
  - If an entry with equal address exists and is not the one being drained: its data is overwritten (coalesce); count unchanged.
  - Otherwise the data is pushed at tail.
  - cache_ready=1 during cycle N+1.
- Write when full (count==DEPTH) and no coalesce is possible: no ready; the request is held. It is accepted on the first edge after a slot frees.
- A slot freed by drain completion at edge M is usable from edge M+1, never at the same edge.
- FSM states: IDLE, DRAIN, READ, RESP.
- IDLE:
  - If a read is pending:
    - If it hits the buffer (youngest matching entry): go to RESP with that entry's data.
    - If it misses: go to READ, drive mem_read=1, mem_addr=cache_addr.
  - Else if count>0: go to DRAIN with the head entry; mem_write=1.
- DRAIN:
  - Hold mem_write, mem_addr, mem_wdata until mem_ready.
  - On mem_ready: pop head, drop mem_write, return to IDLE.
  - A drain in flight is never aborted. A read arriving during DRAIN waits for it.
- READ:
  - Hold mem_read until mem_ready.
  - On mem_ready: capture mem_rdata into cache_rdata, go to RESP.
- RESP: cache_ready=1 for one cycle, then IDLE.
- Priority in IDLE: read > drain. Reads never reorder against buffered writes to the same address because of the hit check.
- Write acceptance runs in parallel with the FSM in every state except the dead cycle above.
- A write and a drain pop at the same edge: count stays unchanged; head and tail both advance.
- Pointers wrap modulo DEPTH.
- wb_empty = (count==0) && state!=DRAIN.

Optional Feature:
- Macro: WBUF_FWD_EN.
- Defined: a read hitting a buffered address is served from the buffer (IDLE->RESP), with cache_ready 2 cycles after the request.
- Undefined:
  - No forwarding compare on reads.
  - A read whose address matches any valid entry forces DRAIN until no matching entry remains, then issues READ to memory.
  - Non-matching reads behave as when defined.

Test Plan:
- Reset with cache_write high and proc_reset pulsed mid-DRAIN -> all outputs 0, wb_empty=1, mem_write drops asynchronously.
- Eviction burst: 4 writes to addr 0x10..0x13, mem_ready delayed 8 cycles:
  - each write gets cache_ready 1 cycle after its request;
  - 5th write (0x14) stalls until the first drain completes;
  - memory sees 0x10,0x11,0x12,0x13,0x14 in order.
- Coalesce: write 0x20 data A, then 0x20 data B while 0x20 is not draining -> count=1; memory receives only B.
- Read forward (WBUF_FWD_EN on): buffered 0x30=0xDEAD..., read 0x30 -> cache_ready+cache_rdata=0xDEAD... 2 cycles later, mem_read never asserted.
- Read miss during drain: drain in flight, read 0x40 -> mem_write completes first, then mem_read for 0x40; cache_rdata equals mem_rdata.
- WBUF_FWD_EN off: buffered 0x30, read 0x30 -> 0x30 written to memory before mem_read 0x30; returned data equals the written data.
